// File: rtl/cpu_io_arbiter.sv
// cpu_io_arbiter: round-robin valid/ready arbiter feeding the CPU input ports,
// plus decode of CPU port writes into a device byte and arbiter commands.
module cpu_io_arbiter #(
    parameter int N_REQ   = 4,
    parameter int TIMEOUT = 200
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N_REQ-1:0]   req_valid,
    input  logic [8*N_REQ-1:0] req_data,
    output logic [N_REQ-1:0]   req_ready,
    input  logic               cpu_we,
    input  logic               cpu_port_sel,
    input  logic [7:0]         cpu_wdata,
    output logic [7:0]         cpu_in_p0,
    output logic [7:0]         cpu_in_p1,
    output logic [7:0]         dev_out,
    output logic               dev_out_valid
);
    typedef enum logic [1:0] {IDLE, GRANT, ACK} state_t;
    state_t state;
    logic [1:0] ptr, id, win, id_nxt;
    logic [7:0] cnt, win_data;
    logic gvalid, sticky, ack, clr, tmo;
    assign ack = cpu_we & cpu_port_sel & (cpu_wdata == 8'h01);
    assign clr = cpu_we & cpu_port_sel & (cpu_wdata == 8'h02);
    assign tmo = cnt == 8'(TIMEOUT - 1);
    assign id_nxt = (id == 2'(N_REQ - 1)) ? 2'd0 : id + 2'd1;
    assign cpu_in_p1 = {gvalid, sticky, 4'b0, id};
    // lowest asserted index overall, then overridden by the lowest at or after ptr
    always_comb begin
        win = '0;
        win_data = '0;
        for (int i = N_REQ - 1; i >= 0; i--)
            if (req_valid[i]) begin
                win = 2'(i);
                win_data = req_data[8*i +: 8];
            end
        for (int i = N_REQ - 1; i >= 0; i--)
            if (req_valid[i] && i >= int'(ptr)) begin
                win = 2'(i);
                win_data = req_data[8*i +: 8];
            end
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            ptr <= '0;
            id <= '0;
            cnt <= '0;
            gvalid <= 1'b0;
            sticky <= 1'b0;
            req_ready <= '0;
            cpu_in_p0 <= '0;
            dev_out <= '0;
            dev_out_valid <= 1'b0;
        end else begin
            dev_out_valid <= cpu_we & ~cpu_port_sel;
            if (cpu_we & ~cpu_port_sel) dev_out <= cpu_wdata;
            req_ready <= '0;
            if (clr) sticky <= 1'b0;
            case (state)
                IDLE: if (|req_valid) begin
                    state <= GRANT;
                    gvalid <= 1'b1;
                    id <= win;
                    cpu_in_p0 <= win_data;
                    cnt <= '0;
                end
                GRANT: begin
                    cnt <= cnt + 8'd1;
                    if (ack) begin
                        state <= ACK;
                        gvalid <= 1'b0;
                        req_ready <= N_REQ'(1) << id;
                        ptr <= id_nxt;
                        id <= '0;
                    end else if (tmo) begin
                        // timeout set overrides a same-cycle clear command
                        state <= IDLE;
                        gvalid <= 1'b0;
                        sticky <= 1'b1;
                        ptr <= id_nxt;
                        id <= '0;
                        cnt <= '0;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt <= '0;
                    id <= '0;
                end
            endcase
        end
    end
endmodule
